// File: rtl/midi_msg_parser.sv
// midi_msg_parser
//   Turns the byte stream from the MIDI receiver into note events.
//   It assembles channel-voice messages and supports running status.
//   It also keeps a monophonic gate/note/velocity state for one synth voice.
//   Realtime bytes are transparent, including inside SysEx.
//   SysEx, system common and non-note channel messages are consumed silently.
//
// Parameters
//   OMNI       1 = accept all channels, 0 = accept LISTEN_CH only
//   LISTEN_CH  channel number (0-15) used when OMNI = 0
//
// Ports
//   clck        system clock
//   rst_n       asynchronous active-low reset
//   byte_in     received MIDI byte, qualified by byte_valid
//   byte_valid  one-cycle strobe per received byte
//   evt_valid   one-cycle pulse per completed note event
//   evt_on      1 = note-on, 0 = note-off (note-on with velocity 0 maps here)
//   evt_ch      channel of the last event
//   evt_note    note number of the last event
//   evt_vel     raw velocity of the last event
//   gate        high while a note is held
//   cur_note    currently sounding note
//   cur_vel     velocity of the current note
//   sync_err    one-cycle pulse: data byte arrived with no running status
//
// State table
//   IDLE    | no running status; data bytes are sync errors
//   WAIT_D1 | running status valid, waiting for the first data byte
//   WAIT_D2 | first data byte stored, waiting for the second
//   SYSEX   | inside a system-exclusive dump; data bytes dropped

module midi_msg_parser #(
    parameter bit         OMNI      = 1'b1,
    parameter logic [3:0] LISTEN_CH = 4'd0
) (
    input  logic       clck,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       evt_valid,
    output logic       evt_on,
    output logic [3:0] evt_ch,
    output logic [6:0] evt_note,
    output logic [6:0] evt_vel,
    output logic       gate,
    output logic [6:0] cur_note,
    output logic [6:0] cur_vel,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] run_status;
    logic       need_two;
    logic [6:0] d1;

    logic is_realtime;
    logic is_chan_status;
    logic is_note_msg;
    logic ch_ok;
    logic note_on_now;

    assign is_realtime    = (byte_in[7:3] == 5'b11111);
    assign is_chan_status = byte_in[7] && (byte_in[7:4] != 4'hF);
    // 8x and 9x share the top three bits; bit 4 separates on from off.
    assign is_note_msg    = (run_status[7:5] == 3'b100);
    assign ch_ok          = OMNI || (run_status[3:0] == LISTEN_CH);
    // Used only while completing a message; byte_in then holds d2.
    assign note_on_now    = run_status[4] && (byte_in[6:0] != 7'd0);

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run_status <= 8'h00;
            need_two   <= 1'b0;
            d1         <= 7'd0;
            evt_valid  <= 1'b0;
            evt_on     <= 1'b0;
            evt_ch     <= 4'd0;
            evt_note   <= 7'd0;
            evt_vel    <= 7'd0;
            gate       <= 1'b0;
            cur_note   <= 7'd0;
            cur_vel    <= 7'd0;
            sync_err   <= 1'b0;
        end else begin
            evt_valid <= 1'b0;
            sync_err  <= 1'b0;

            if (byte_valid && !is_realtime) begin
                if (is_chan_status) begin
                    // A status arriving mid-message simply restarts assembly.
                    run_status <= byte_in;
                    need_two   <= (byte_in[7:5] != 3'b110);
                    state      <= WAIT_D1;
                end else if (byte_in[7]) begin
                    run_status <= 8'h00;
                    state      <= (byte_in == 8'hF0) ? SYSEX : IDLE;
                end else begin
                    unique case (state)
                        IDLE: begin
                            sync_err <= 1'b1;
                        end
                        WAIT_D1: begin
                            d1 <= byte_in[6:0];
                            // One-byte messages (Cx/Dx) are never note events,
                            // so completing them needs no output.
                            if (need_two) begin
                                state <= WAIT_D2;
                            end
                        end
                        WAIT_D2: begin
                            state <= WAIT_D1;
                            if (is_note_msg && ch_ok) begin
                                evt_valid <= 1'b1;
                                evt_on    <= note_on_now;
                                evt_ch    <= run_status[3:0];
                                evt_note  <= d1;
                                evt_vel   <= byte_in[6:0];
                                if (note_on_now) begin
                                    gate     <= 1'b1;
                                    cur_note <= d1;
                                    cur_vel  <= byte_in[6:0];
                                end else if (gate && (d1 == cur_note)) begin
                                    gate <= 1'b0;
                                end
                            end
                        end
                        SYSEX: begin
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser
//   Directed byte sequences with hand-computed expectations.
//   dut runs in OMNI mode; dut_f listens on channel 3 only and sees the same stream.

module tb_midi_msg_parser;

    logic       clck;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;

    logic       evt_valid, evt_on, gate, sync_err;
    logic [3:0] evt_ch;
    logic [6:0] evt_note, evt_vel, cur_note, cur_vel;

    logic       f_evt_valid, f_evt_on, f_gate, f_sync_err;
    logic [3:0] f_evt_ch;
    logic [6:0] f_evt_note, f_evt_vel, f_cur_note, f_cur_vel;

    int total = 0;
    int bad   = 0;

    int ev_cnt = 0, sync_cnt = 0, fev_cnt = 0;
    int last_on, last_ch, last_note, last_vel, flast_ch;

    midi_msg_parser #(.OMNI(1'b1), .LISTEN_CH(4'd0)) dut (
        .clck(clck), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_valid(evt_valid), .evt_on(evt_on), .evt_ch(evt_ch),
        .evt_note(evt_note), .evt_vel(evt_vel), .gate(gate),
        .cur_note(cur_note), .cur_vel(cur_vel), .sync_err(sync_err)
    );

    midi_msg_parser #(.OMNI(1'b0), .LISTEN_CH(4'd3)) dut_f (
        .clck(clck), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_valid(f_evt_valid), .evt_on(f_evt_on), .evt_ch(f_evt_ch),
        .evt_note(f_evt_note), .evt_vel(f_evt_vel), .gate(f_gate),
        .cur_note(f_cur_note), .cur_vel(f_cur_vel), .sync_err(f_sync_err)
    );

    initial clck = 1'b0;
    always #10 clck = ~clck;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clck) begin
        if (evt_valid) begin
            ev_cnt    <= ev_cnt + 1;
            last_on   <= int'(evt_on);
            last_ch   <= int'(evt_ch);
            last_note <= int'(evt_note);
            last_vel  <= int'(evt_vel);
        end
        if (sync_err) sync_cnt <= sync_cnt + 1;
        if (f_evt_valid) begin
            fev_cnt  <= fev_cnt + 1;
            flast_ch <= int'(f_evt_ch);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clck);
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clck);
    endtask

    initial begin
        int ev0, sy0, fe0;
        rst_n      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_cur_note", int'(cur_note), 0);
        chk("rst_evt_vel", int'(evt_vel), 0);
        chk("rst_sync_err", int'(sync_err), 0);

        // Note-on with exact one-cycle latency.
        send(8'h90); send(8'h3C); send(8'h64);
        #1;
        chk("on_evt_valid", int'(evt_valid), 1);
        chk("on_evt_on", int'(evt_on), 1);
        chk("on_evt_ch", int'(evt_ch), 0);
        chk("on_evt_note", int'(evt_note), 8'h3C);
        chk("on_evt_vel", int'(evt_vel), 8'h64);
        chk("on_gate", int'(gate), 1);
        chk("on_cur_note", int'(cur_note), 8'h3C);
        chk("on_cur_vel", int'(cur_vel), 8'h64);
        idle(1);
        chk("on_pulse_one_cycle", int'(evt_valid), 0);
        idle(1);
        chk("on_ev_cnt", ev_cnt, 1);

        // Running status: 3C 00 is a note-off.
        send(8'h3C); send(8'h00);
        idle(2);
        chk("rs_ev_cnt", ev_cnt, 2);
        chk("rs_on", last_on, 0);
        chk("rs_note", last_note, 8'h3C);
        chk("rs_vel", last_vel, 0);
        chk("rs_gate", int'(gate), 0);
        chk("rs_cur_note_hold", int'(cur_note), 8'h3C);
        chk("rs_cur_vel_hold", int'(cur_vel), 8'h64);

        // Realtime between data bytes.
        send(8'h91); send(8'h40); send(8'hF8); send(8'h7F);
        idle(2);
        chk("rt_ev_cnt", ev_cnt, 3);
        chk("rt_ch", last_ch, 1);
        chk("rt_note", last_note, 8'h40);
        chk("rt_vel", last_vel, 8'h7F);
        chk("rt_on", last_on, 1);
        chk("rt_cur_note", int'(cur_note), 8'h40);
        chk("rt_sync_cnt", sync_cnt, 0);

        // SysEx with embedded realtime, then an orphan data byte.
        send(8'hF0); send(8'h01); send(8'hF8); send(8'h02); send(8'hF7); send(8'h45);
        idle(2);
        chk("sx_ev_cnt", ev_cnt, 3);
        chk("sx_sync_cnt", sync_cnt, 1);
        send(8'h92); send(8'h45); send(8'h10);
        idle(2);
        chk("sx_after_ev_cnt", ev_cnt, 4);
        chk("sx_after_ch", last_ch, 2);
        chk("sx_after_note", last_note, 8'h45);
        chk("sx_after_vel", last_vel, 8'h10);
        chk("sx_after_sync_cnt", sync_cnt, 1);

        // Channel filter on dut_f (channel 3 only).
        chk("flt_none_yet", fev_cnt, 0);
        send(8'h95); send(8'h30); send(8'h40);
        send(8'h93); send(8'h30); send(8'h40);
        idle(2);
        chk("flt_fev_cnt", fev_cnt, 1);
        chk("flt_ch", flast_ch, 3);
        chk("flt_gate", int'(f_gate), 1);
        chk("flt_cur_note", int'(f_cur_note), 8'h30);
        chk("flt_omni_ev_cnt", ev_cnt, 6);
        ev0 = ev_cnt; fe0 = fev_cnt; sy0 = sync_cnt;
        send(8'hC3); send(8'h05); send(8'h30);
        idle(2);
        chk("pc_ev_cnt", ev_cnt, ev0);
        chk("pc_fev_cnt", fev_cnt, fe0);
        chk("pc_sync_cnt", sync_cnt, sy0);

        // Note-off for a different note leaves the gate; matching one clears it.
        send(8'h83); send(8'h31); send(8'h00);
        idle(2);
        chk("off_other_gate", int'(gate), 1);
        chk("off_other_ev_cnt", ev_cnt, ev0 + 1);
        send(8'h30); send(8'h7F);
        idle(2);
        chk("off_match_gate", int'(gate), 0);
        chk("off_match_vel", last_vel, 8'h7F);
        chk("off_match_on", last_on, 0);
        chk("off_cur_vel_hold", int'(cur_vel), 8'h40);

        // Status in WAIT_D2 abandons the partial note-on.
        ev0 = ev_cnt;
        send(8'h90); send(8'h50); send(8'h80); send(8'h50); send(8'h20);
        idle(2);
        chk("abandon_ev_cnt", ev_cnt, ev0 + 1);
        chk("abandon_on", last_on, 0);
        chk("abandon_note", last_note, 8'h50);
        chk("abandon_vel", last_vel, 8'h20);
        chk("abandon_gate", int'(gate), 0);

        // Reset mid-message.
        ev0 = ev_cnt; sy0 = sync_cnt;
        send(8'h90); send(8'h3C);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h64);
        idle(2);
        chk("mid_rst_ev_cnt", ev_cnt, ev0);
        chk("mid_rst_sync_cnt", sync_cnt, sy0 + 1);
        chk("mid_rst_gate", int'(gate), 0);
        chk("mid_rst_cur_note", int'(cur_note), 0);
        chk("mid_rst_cur_vel", int'(cur_vel), 0);
        chk("mid_rst_evt_note", int'(evt_note), 0);
        chk("mid_rst_evt_vel", int'(evt_vel), 0);
        chk("mid_rst_evt_ch", int'(evt_ch), 0);
        chk("mid_rst_evt_on", int'(evt_on), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Consumes the byte stream from midiReceive: one 8-bit byte plus a one-cycle valid strobe per received MIDI byte.
- Assembles channel-voice messages with full running-status support and emits decoded note-on/note-off events.
- Keeps a monophonic gate/note/velocity state for the downstream synth voice.
- Discards all other traffic (SysEx, system common, realtime, non-note channel messages) without losing sync.

Parameters:
- OMNI, 1: 1 = accept every channel; 0 = accept only LISTEN_CH.
- LISTEN_CH, 0: 4-bit channel number (0-15) used when OMNI=0.

Ports:
- clck  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- byte_in  in  8  received MIDI byte, sampled only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe from receiver; back-to-back strobes on consecutive cycles are legal.
- evt_valid  out  1  one-cycle pulse: note event completed.
- evt_on  out  1  1 = note-on, 0 = note-off; valid with evt_valid.
- evt_ch  out  4  channel of the event.
- evt_note  out  7  note number of the event.
- evt_vel  out  7  velocity of the event; raw value, including 0 for note-on velocity 0.
- gate  out  1  1 while a note is held.
- cur_note  out  7  currently sounding note.
- cur_vel  out  7  velocity of the current note.
- sync_err  out  1  one-cycle pulse: data byte received with no running status.

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0; running status cleared; state IDLE.
  - Reset mid-message discards the partial message; no event is emitted.
- Byte classes, evaluated only on byte_valid:
  - Realtime (F8-FF): ignored completely. State, running status and stored data are untouched, including inside SysEx.
  - Status 80-EF: load running status, set expected data count, go to WAIT_D1. Expected count is 1 for Cx/Dx and 2 otherwise.
  - F0: clear running status, go to SYSEX.
  - F1-F7: clear running status, go to IDLE. F7 also ends SYSEX.
  - Data 00-7F: handled per state below.
- States:
  - IDLE: a data byte pulses sync_err and is dropped.
  - WAIT_D1: a data byte is stored as d1. If the expected count is 1, the message is complete and state returns to WAIT_D1 under running status; otherwise go to WAIT_D2.
  - WAIT_D2: a data byte is stored as d2, the message is complete, and state returns to WAIT_D1 (running status kept).
  - SYSEX: data bytes are dropped, with no sync_err. F7 or any status 80-F6 exits with that byte's normal handling.
- A new status byte arriving in WAIT_D2 abandons the partial message with no event.
- Message completion:
  - Event emitted only for 9x/8x messages on an accepted channel.
  - Rejected channels and other messages: consumed silently.
  - 9x with d2>0 gives evt_on=1. 8x, or 9x with d2=0, gives evt_on=0.
- Latency:
  - evt_valid is registered and asserts the cycle after the byte_valid carrying d2.
  - evt_ch, evt_note, evt_vel are stable in that cycle and hold their values until the next event.
- Monophonic state, updated in the same cycle as evt_valid:
  - Note-on: gate=1, cur_note=note, cur_vel=vel. Last note wins.
  - Note-off with note==cur_note while gate=1: gate=0; cur_note and cur_vel hold.
  - Note-off for any other note: gate unchanged.

Test Plan:
- Note-on: reset, send 90 3C 64 -> one evt_valid cycle after the 3rd strobe; evt_on=1, ch=0, note=0x3C, vel=0x64; gate=1, cur_note=0x3C.
- Running status: send 90 3C 64 then 3C 00 -> second event evt_on=0, note=0x3C, vel=0; gate=0; cur_note holds 0x3C.
- Realtime interleave: send 91 40 F8 7F (F8 between the data bytes) -> single event ch=1, note=0x40, vel=0x7F; F8 alters nothing.
- SysEx: send F0 01 02 F7 then 45 -> no events; sync_err pulses exactly once, for the 45. Then send 92 45 10 -> note-on ch=2.
- Channel filter: OMNI=0, LISTEN_CH=3. Send 95 30 40 then 93 30 40 -> only the second produces evt_valid. Program change C3 05 -> no event; the next 30 is accepted under running status as a program change, so still no event.
- Reset mid-message: send 90 3C, assert rst_n low for 2 cycles, release, send 64 -> no event; sync_err pulses; all outputs remain 0.
